// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // A transfer is in error if its size code is illegal or the address is not
   // naturally aligned for that size.
   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lsb);
      logic bad;
      case (sz)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lsb[0];
         SZ_WORD: bad = (lsb != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word RAM with per-byte-lane write enables and a registered read.
// Contents are never reset.
module dmem_bank #(
   parameter int DEPTH = 4096,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [IW-1:0] idx,
   input  logic [31:0]   din,
   output logic [31:0]   dout
);

   logic [31:0] mem [DEPTH];
   logic [31:0] dout_q;

   // Read-first access: dout reflects the word as it was before any lane write.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
               mem[idx][8*i +: 8] <= din[8*i +: 8];
            end
         end
         dout_q <= mem[idx];
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time, waits LATENCY cycles,
// then returns a single-cycle data_ok with read data or a write acknowledge.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 4096,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int         IW         = $clog2(DEPTH);
   localparam int         CNT_INIT_I = (LATENCY > 0) ? LATENCY - 1 : 0;
   localparam logic [3:0] CNT_INIT   = 4'(CNT_INIT_I);
   localparam bit         HAS_WAIT   = (LATENCY > 0);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          data_ok_q, data_ok_d;
   logic          resp_err_q, resp_err_d;
   logic          zero_q, zero_d;

   logic          lwr_q, lwr_d;
   logic          lerr_q, lerr_d;
   logic [IW-1:0] lidx_q, lidx_d;
   logic [3:0]    lstrb_q, lstrb_d;
   logic [31:0]   ldata_q, ldata_d;

   logic          req_err;
   logic          accept;
   logic          cur_wr;
   logic          cur_err;
   logic [IW-1:0] cur_idx;
   logic [3:0]    cur_strb;
   logic [31:0]   cur_data;
   logic          bank_en;
   logic [3:0]    bank_we;
   logic [31:0]   bank_dout;

   // Upper address bits do not select anything: the array wraps.
   logic          unused_addr;
   assign unused_addr = ^addr[31:IW+2];

   // Decode the live request; in IDLE the bank sees it directly so that a
   // zero-latency access completes on the acceptance edge.
   always_comb begin
      req_err = misaligned(size, addr[1:0]);
      accept  = (state_q == IDLE) && req;
      if (state_q == IDLE) begin
         cur_wr   = wr;
         cur_err  = req_err;
         cur_idx  = addr[IW+1:2];
         cur_strb = wstrb;
         cur_data = wdata;
      end else begin
         cur_wr   = lwr_q;
         cur_err  = lerr_q;
         cur_idx  = lidx_q;
         cur_strb = lstrb_q;
         cur_data = ldata_q;
      end
   end

   // Capture the request only on the acceptance edge.
   always_comb begin
      lwr_d   = lwr_q;
      lerr_d  = lerr_q;
      lidx_d  = lidx_q;
      lstrb_d = lstrb_q;
      ldata_d = ldata_q;
      if (accept) begin
         lwr_d   = wr;
         lerr_d  = req_err;
         lidx_d  = addr[IW+1:2];
         lstrb_d = wstrb;
         ldata_d = wdata;
      end
   end

   // Next state, wait counter and the response flags registered on entry to RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (HAS_WAIT) begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      bank_en    = (state_d == RESP);
      bank_we    = (bank_en && cur_wr && !cur_err) ? cur_strb : 4'b0000;
      data_ok_d  = bank_en;
      resp_err_d = bank_en && cur_err;
      zero_d     = cur_wr || cur_err;
   end

   // Control state: an asynchronous reset drops any pending request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         data_ok_q  <= 1'b0;
         resp_err_q <= 1'b0;
         zero_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         data_ok_q  <= data_ok_d;
         resp_err_q <= resp_err_d;
         zero_q     <= zero_d;
      end
   end

   // Request latch holds data only; no reset needed.
   always_ff @(posedge clk) begin
      lwr_q   <= lwr_d;
      lerr_q  <= lerr_d;
      lidx_q  <= lidx_d;
      lstrb_q <= lstrb_d;
      ldata_q <= ldata_d;
   end

   dmem_bank #(
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_bank (
      .clk  (clk),
      .en   (bank_en),
      .we   (bank_we),
      .idx  (cur_idx),
      .din  (cur_data),
      .dout (bank_dout)
   );

   assign addr_ok = (state_q == IDLE);
   assign data_ok = data_ok_q;
   assign err     = resp_err_q;
   assign rdata   = (data_ok_q && !zero_q) ? bank_dout : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// Scoreboard bench: three responders (LATENCY 2, 0, 3) share one clock.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int N = 3;
   localparam int LAT [N] = '{2, 0, 3};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n   [N];
   logic        req     [N];
   logic        wr      [N];
   logic [1:0]  size    [N];
   logic [31:0] addr    [N];
   logic [3:0]  wstrb   [N];
   logic [31:0] wdata   [N];
   logic        addr_ok [N];
   logic        data_ok [N];
   logic [31:0] rdata   [N];
   logic        err     [N];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // entry = {expected negedge cycle[31:0], err, rdata[31:0]}
   logic [64:0] sb0[$];
   logic [64:0] sb1[$];
   logic [64:0] sb2[$];

   dmem_responder #(.DEPTH(4096), .LATENCY(2)) u_l2 (
      .clk(clk), .reset(rst_n[0]), .req(req[0]), .wr(wr[0]), .size(size[0]),
      .addr(addr[0]), .wstrb(wstrb[0]), .wdata(wdata[0]), .addr_ok(addr_ok[0]),
      .data_ok(data_ok[0]), .rdata(rdata[0]), .err(err[0]));

   dmem_responder #(.DEPTH(4096), .LATENCY(0)) u_l0 (
      .clk(clk), .reset(rst_n[1]), .req(req[1]), .wr(wr[1]), .size(size[1]),
      .addr(addr[1]), .wstrb(wstrb[1]), .wdata(wdata[1]), .addr_ok(addr_ok[1]),
      .data_ok(data_ok[1]), .rdata(rdata[1]), .err(err[1]));

   dmem_responder #(.DEPTH(4096), .LATENCY(3)) u_l3 (
      .clk(clk), .reset(rst_n[2]), .req(req[2]), .wr(wr[2]), .size(size[2]),
      .addr(addr[2]), .wstrb(wstrb[2]), .wdata(wdata[2]), .addr_ok(addr_ok[2]),
      .data_ok(data_ok[2]), .rdata(rdata[2]), .err(err[2]));

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic sb_push(input int g, input logic [64:0] e);
      case (g)
         0:       sb0.push_back(e);
         1:       sb1.push_back(e);
         default: sb2.push_back(e);
      endcase
   endtask

   task automatic sb_pop(input int g, output logic [64:0] e, output bit ok);
      ok = 1'b0;
      e  = '0;
      case (g)
         0:       if (sb0.size() > 0) begin e = sb0.pop_front(); ok = 1'b1; end
         1:       if (sb1.size() > 0) begin e = sb1.pop_front(); ok = 1'b1; end
         default: if (sb2.size() > 0) begin e = sb2.pop_front(); ok = 1'b1; end
      endcase
   endtask

   // Monitor: every data_ok pulse must match the oldest expected response.
   always @(negedge clk) begin
      logic [64:0] e;
      bit          ok;
      for (int g = 0; g < N; g++) begin
         if (data_ok[g] !== 1'b0) begin
            sb_pop(g, e, ok);
            if (!ok) begin
               total++;
               bad++;
               $display("FAIL unexpected_data_ok inst%0d: got data_ok=%b rdata=%h expected no response (cycle %0d)",
                        g, data_ok[g], rdata[g], cyc);
            end else begin
               chk($sformatf("rdata_i%0d", g), rdata[g], e[31:0]);
               chk($sformatf("err_i%0d", g), 32'(err[g]), 32'(e[32]));
               chk($sformatf("resp_cycle_i%0d", g), cyc, e[64:33]);
            end
         end else begin
            chk($sformatf("err_idle_i%0d", g), 32'(err[g]), 32'd0);
         end
      end
   end

   // Drive one request when the responder is ready; inputs are scrambled
   // right after acceptance to show they are not re-sampled.
   task automatic issue(input int g, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [3:0] st, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input bit expect_resp, input bit hold);
      int n = 0;
      @(negedge clk);
      while (addr_ok[g] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL accept_timeout inst%0d: got addr_ok=%b expected 1 within 50 cycles", g, addr_ok[g]);
         return;
      end
      req[g]   = 1'b1;
      wr[g]    = w;
      size[g]  = sz;
      addr[g]  = a;
      wstrb[g] = st;
      wdata[g] = d;
      if (expect_resp) sb_push(g, {32'(cyc + 1 + LAT[g]), exp_err, exp_rd});
      @(posedge clk);
      #1;
      addr[g]  = ~a;
      wdata[g] = ~d;
      wstrb[g] = ~st;
      wr[g]    = ~w;
      if (!hold) req[g] = 1'b0;
   endtask

   initial begin
      for (int g = 0; g < N; g++) begin
         rst_n[g] = 1'b1; req[g] = 1'b0; wr[g] = 1'b0; size[g] = SZ_WORD;
         addr[g] = '0; wstrb[g] = '0; wdata[g] = '0;
      end
      u_l2.u_bank.mem[4]  = 32'hDEADBEEF;  // byte addr 0x10
      u_l2.u_bank.mem[8]  = 32'h11223344;  // 0x20
      u_l2.u_bank.mem[16] = 32'h55667788;  // 0x40
      u_l2.u_bank.mem[2]  = 32'h00000000;  // 0x08
      u_l2.u_bank.mem[12] = 32'h0F1E2D3C;  // 0x30
      u_l0.u_bank.mem[64] = 32'hA0000001;  // 0x100
      u_l0.u_bank.mem[65] = 32'hB0000002;  // 0x104
      u_l0.u_bank.mem[66] = 32'hC0000003;  // 0x108
      u_l0.u_bank.mem[67] = 32'hD0000004;  // 0x10C
      u_l0.u_bank.mem[128] = 32'h12345678; // 0x200
      u_l3.u_bank.mem[32] = 32'h0BADC0DE;  // 0x80
      #2;
      for (int g = 0; g < N; g++) rst_n[g] = 1'b0;
      repeat (3) @(negedge clk);
      for (int g = 0; g < N; g++) rst_n[g] = 1'b1;
      #1;
      for (int g = 0; g < N; g++) begin
         chk($sformatf("rst_addr_ok_i%0d", g), 32'(addr_ok[g]), 32'd1);
         chk($sformatf("rst_data_ok_i%0d", g), 32'(data_ok[g]), 32'd0);
         chk($sformatf("rst_rdata_i%0d", g), rdata[g], 32'd0);
         chk($sformatf("rst_err_i%0d", g), 32'(err[g]), 32'd0);
      end

      // Basic read with two wait states; addr_ok low through WAIT, WAIT, RESP.
      issue(0, 1'b0, SZ_WORD, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("busy_addr_ok_%0d", i), 32'(addr_ok[0]), 32'd0);
      end

      // Byte lane write then read back.
      issue(0, 1'b1, SZ_BYTE, 32'h21, 4'b0010, 32'h0000AB00, 32'h0, 1'b0, 1'b1, 1'b0);
      issue(0, 1'b0, SZ_WORD, 32'h20, 4'h0, 32'h0, 32'h1122AB44, 1'b0, 1'b1, 1'b0);

      // Misaligned half write is flagged and commits nothing.
      issue(0, 1'b1, SZ_HALF, 32'h43, 4'b1100, 32'h99AA0000, 32'h0, 1'b1, 1'b1, 1'b0);
      issue(0, 1'b0, SZ_WORD, 32'h40, 4'h0, 32'h0, 32'h55667788, 1'b0, 1'b1, 1'b0);

      // Address wrap modulo 4*DEPTH bytes.
      issue(0, 1'b1, SZ_WORD, 32'h00004008, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, 1'b0);
      issue(0, 1'b0, SZ_WORD, 32'h00000008, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0);

      // Erroneous reads return 0; wstrb=0 write is an acknowledged no-op.
      issue(0, 1'b0, SZ_WORD, 32'h12, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      issue(0, 1'b0, 2'd3, 32'h10, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      issue(0, 1'b1, SZ_WORD, 32'h30, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0);
      issue(0, 1'b0, SZ_HALF, 32'h32, 4'h0, 32'h0, 32'h0F1E2D3C, 1'b0, 1'b1, 1'b0);

      // Zero latency with req held: four reads, one every two cycles.
      issue(1, 1'b0, SZ_WORD, 32'h100, 4'h0, 32'h0, 32'hA0000001, 1'b0, 1'b1, 1'b1);
      issue(1, 1'b0, SZ_WORD, 32'h104, 4'h0, 32'h0, 32'hB0000002, 1'b0, 1'b1, 1'b1);
      issue(1, 1'b0, SZ_BYTE, 32'h10B, 4'h0, 32'h0, 32'hC0000003, 1'b0, 1'b1, 1'b1);
      issue(1, 1'b0, SZ_WORD, 32'h10C, 4'h0, 32'h0, 32'hD0000004, 1'b0, 1'b1, 1'b0);

      // Back-to-back write then read of the same word with req held.
      issue(1, 1'b1, SZ_WORD, 32'h200, 4'b1001, 32'hAABBCCDD, 32'h0, 1'b0, 1'b1, 1'b1);
      issue(1, 1'b0, SZ_WORD, 32'h200, 4'h0, 32'h0, 32'hAA3456DD, 1'b0, 1'b1, 1'b0);

      // Reset during WAIT drops the write.
      issue(2, 1'b1, SZ_WORD, 32'h80, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n[2] = 1'b0;
      #1;
      chk("midrst_addr_ok", 32'(addr_ok[2]), 32'd1);
      chk("midrst_data_ok", 32'(data_ok[2]), 32'd0);
      repeat (2) @(negedge clk);
      rst_n[2] = 1'b1;
      repeat (5) @(negedge clk);
      issue(2, 1'b0, SZ_WORD, 32'h80, 4'h0, 32'h0, 32'h0BADC0DE, 1'b0, 1'b1, 1'b0);

      repeat (10) @(negedge clk);
      chk("sb0_drained", 32'(sb0.size()), 32'd0);
      chk("sb1_drained", 32'(sb1.size()), 32'd0);
      chk("sb2_drained", 32'(sb2.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
